// File: rtl/wavetable_dds_synth_if.sv
// wavetable_dds_synth_if: control, table-write and audio-output signals of the wavetable DDS player.
interface wavetable_dds_synth_if #(
    parameter int SAMPLE_W = 8,
    parameter int ADDR_W   = 5,
    parameter int PHASE_W  = 16
);
    logic                Switch;
    logic [PHASE_W-1:0]  FREQ;
    logic                WR_EN;
    logic [ADDR_W-1:0]   WR_ADDR;
    logic [SAMPLE_W-1:0] WR_DATA;
    logic [SAMPLE_W-1:0] SAMPLE;
    logic                SAMPLE_STB;
    logic                AudioBit;
    modport master (output Switch, FREQ, WR_EN, WR_ADDR, WR_DATA, input SAMPLE, SAMPLE_STB, AudioBit);
    modport slave  (input Switch, FREQ, WR_EN, WR_ADDR, WR_DATA, output SAMPLE, SAMPLE_STB, AudioBit);
endinterface

// File: rtl/wavetable_dds_synth.sv
// wavetable_dds_synth: writable wavetable stepped by a phase accumulator, parallel sample plus 1-bit audio.
// Define WAVETABLE_PDM_EN for a sigma-delta AudioBit; otherwise AudioBit follows the sample MSB.
module wavetable_dds_synth #(
    parameter int SAMPLE_W = 8,
    parameter int ADDR_W   = 5,
    parameter int PHASE_W  = 16,
    parameter int CLK_DIV  = 1
) (
    input logic CLK,
    input logic RST_N,
    wavetable_dds_synth_if.slave bus
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [SAMPLE_W-1:0] wave [2**ADDR_W];
    logic [PHASE_W-1:0]  phase;
    logic [DIV_W-1:0]    div;
    logic [SAMPLE_W-1:0] sample_q;
    logic                stb_q;
    logic                bit_q;
    logic                tick;
    assign tick           = bus.Switch && div == DIV_W'(CLK_DIV - 1);
    assign bus.SAMPLE     = sample_q;
    assign bus.SAMPLE_STB = stb_q;
    assign bus.AudioBit   = bit_q;
    // Table is not reset; non-blocking update gives read-before-write on collisions.
    always_ff @(posedge CLK)
        if (bus.WR_EN) wave[bus.WR_ADDR] <= bus.WR_DATA;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase    <= '0;
            div      <= '0;
            sample_q <= '0;
            stb_q    <= 1'b0;
        end else if (!bus.Switch) begin
            phase    <= '0;
            div      <= '0;
            sample_q <= '0;
            stb_q    <= 1'b0;
        end else begin
            div   <= tick ? '0 : div + 1'b1;
            stb_q <= tick;
            if (tick) begin
                sample_q <= wave[phase[PHASE_W-1 -: ADDR_W]];
                phase    <= phase + bus.FREQ;
            end
        end
    end
`ifdef WAVETABLE_PDM_EN
    // {bit_q, acc} together form the SAMPLE_W+1 bit accumulator; bit_q is its carry.
    logic [SAMPLE_W-1:0] acc;
    logic [SAMPLE_W:0]   acc_nxt;
    assign acc_nxt = {1'b0, acc} + {1'b0, sample_q};
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc   <= '0;
            bit_q <= 1'b0;
        end else if (!bus.Switch) begin
            acc   <= '0;
            bit_q <= 1'b0;
        end else begin
            acc   <= acc_nxt[SAMPLE_W-1:0];
            bit_q <= acc_nxt[SAMPLE_W];
        end
    end
`else
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) bit_q <= 1'b0;
        else        bit_q <= bus.Switch && sample_q[SAMPLE_W-1];
`endif
endmodule

// File: tb/tb_wavetable_dds_synth.sv
// tb_wavetable_dds_synth: randomized and directed checks of the wavetable DDS against a behavioural model.
// Expected AudioBit follows WAVETABLE_PDM_EN the same way the design does.
module tb_wavetable_dds_synth;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    wavetable_dds_synth_if bus ();
    wavetable_dds_synth_if bus4 ();
    wavetable_dds_synth dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
    wavetable_dds_synth #(.CLK_DIV(4)) dut4 (.CLK(CLK), .RST_N(RST_N), .bus(bus4));

    int tbl [32];
    int m_phase, m_sample, m_stb, m_bit, m_acc;
    int compared = 0;
    int mismatched = 0;

    task automatic model_clear();
        m_phase = 0; m_sample = 0; m_stb = 0; m_bit = 0; m_acc = 0;
    endtask

    // Advance the model by one clock from the inputs present before the edge, then let the edge happen.
    task automatic cyc();
        int s;
        if (!bus.Switch) model_clear();
        else begin
            s = m_sample;
`ifdef WAVETABLE_PDM_EN
            m_acc = m_acc % 256 + s;
            m_bit = m_acc / 256;
`else
            m_bit = s / 128;
`endif
            m_sample = tbl[m_phase / 2048];
            m_phase  = (m_phase + int'(bus.FREQ)) % 65536;
            m_stb    = 1;
        end
        if (bus.WR_EN) tbl[bus.WR_ADDR] = int'(bus.WR_DATA);
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        bus.WR_EN = 1'b1; bus.WR_ADDR = 5'(a); bus.WR_DATA = 8'(d);
        bus4.WR_EN = 1'b1; bus4.WR_ADDR = 5'(a); bus4.WR_DATA = 8'(d);
        cyc();
        bus.WR_EN = 1'b0; bus4.WR_EN = 1'b0;
    endtask

    task automatic fill(input int v);
        bus.Switch = 1'b0;
        for (int i = 0; i < 32; i++) wr(i, v < 0 ? 8 * i : v);
    endtask

    task automatic test_reset();
        bus.Switch = 1'b0; bus.FREQ = '0; bus.WR_EN = 1'b0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
        bus4.Switch = 1'b0; bus4.FREQ = '0; bus4.WR_EN = 1'b0; bus4.WR_ADDR = '0; bus4.WR_DATA = '0;
        RST_N = 1'b0;
        model_clear();
        repeat (3) @(posedge CLK);
        #1;
        compared++;
        if ({bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit} !== 10'd0) begin
            mismatched++; $display("FAIL reset: got s=%0d stb=%0b bit=%0b want 0/0/0", bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit);
        end
        compared++;
        if ({bus4.SAMPLE, bus4.SAMPLE_STB, bus4.AudioBit} !== 10'd0) begin
            mismatched++; $display("FAIL reset_div4: got s=%0d stb=%0b bit=%0b want 0/0/0", bus4.SAMPLE, bus4.SAMPLE_STB, bus4.AudioBit);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_ramp();
        fill(-1);
        bus.FREQ = 16'h0800; bus.Switch = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            compared++;
            if ({bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit} !== {8'(m_sample), m_stb[0], m_bit[0]}) begin
                mismatched++; $display("FAIL ramp edge %0d: got s=%0d stb=%0b bit=%0b want s=%0d stb=%0d bit=%0d", k, bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit, m_sample, m_stb, m_bit);
            end
            compared++;
            if (bus.SAMPLE !== 8'(8 * ((k - 1) % 32))) begin
                mismatched++; $display("FAIL ramp_value edge %0d: got %0d want %0d", k, bus.SAMPLE, 8 * ((k - 1) % 32));
            end
        end
    endtask

    task automatic test_half_zero();
        bus.Switch = 1'b0; cyc();
        bus.FREQ = 16'h0400; bus.Switch = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            compared++;
            if ({bus.SAMPLE, bus.SAMPLE_STB} !== {8'(8 * ((k - 1) / 2)), 1'b1}) begin
                mismatched++; $display("FAIL half_rate edge %0d: got s=%0d stb=%0b want s=%0d stb=1", k, bus.SAMPLE, bus.SAMPLE_STB, 8 * ((k - 1) / 2));
            end
        end
        bus.Switch = 1'b0; cyc();
        bus.FREQ = '0; bus.Switch = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            compared++;
            if ({bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit} !== {8'(m_sample), m_stb[0], m_bit[0]} || bus.SAMPLE !== 8'd0) begin
                mismatched++; $display("FAIL zero_rate edge %0d: got s=%0d stb=%0b bit=%0b want s=0 stb=1 bit=%0d", k, bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit, m_bit);
            end
        end
        bus.Switch = 1'b0; cyc();
    endtask

    task automatic test_prescale();
        int ph;
        logic exp_stb;
        ph = 0;
        bus4.FREQ = 16'h0800; bus4.Switch = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            cyc();
            exp_stb = (e % 4 == 0);
            compared++;
            if (bus4.SAMPLE_STB !== exp_stb || (exp_stb && bus4.SAMPLE !== 8'(8 * (ph / 2048)))) begin
                mismatched++; $display("FAIL prescale edge %0d: got s=%0d stb=%0b want stb=%0b s=%0d", e, bus4.SAMPLE, bus4.SAMPLE_STB, exp_stb, 8 * (ph / 2048));
            end
            if (exp_stb) ph = (ph + int'(bus4.FREQ)) % 65536;
            if (e == 12) bus4.FREQ = 16'h1000;
        end
        bus4.Switch = 1'b0; cyc();
    endtask

    task automatic test_switch_reset();
        bus.FREQ = 16'h0800; bus.Switch = 1'b1;
        for (int i = 0; i < 40 && bus.SAMPLE !== 8'd40; i++) cyc();
        compared++;
        if (bus.SAMPLE !== 8'd40) begin
            mismatched++; $display("FAIL reach_40: got %0d want 40", bus.SAMPLE);
        end
        bus.Switch = 1'b0; cyc();
        compared++;
        if ({bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit} !== 10'd0) begin
            mismatched++; $display("FAIL switch_off: got s=%0d stb=%0b bit=%0b want 0/0/0", bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit);
        end
        bus.Switch = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            compared++;
            if (bus.SAMPLE !== 8'(8 * k) || bus.SAMPLE !== 8'(m_sample)) begin
                mismatched++; $display("FAIL restart %0d: got %0d want %0d", k, bus.SAMPLE, 8 * k);
            end
        end
        #2 RST_N = 1'b0;
        #1;
        model_clear();
        compared++;
        if ({bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit} !== 10'd0) begin
            mismatched++; $display("FAIL async_reset: got s=%0d stb=%0b bit=%0b want 0/0/0", bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit);
        end
        #1 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        model_clear();
        m_sample = tbl[0]; m_stb = 1; m_phase = 16'h0800;
        for (int k = 0; k < 6; k++) begin
            cyc();
            compared++;
            if ({bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit} !== {8'(m_sample), m_stb[0], m_bit[0]}) begin
                mismatched++; $display("FAIL after_reset %0d: got s=%0d stb=%0b bit=%0b want s=%0d stb=%0d bit=%0d", k, bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit, m_sample, m_stb, m_bit);
            end
        end
        bus.Switch = 1'b0; cyc();
    endtask

    task automatic test_collision();
        bus.FREQ = 16'h0800; bus.Switch = 1'b1;
        repeat (3) cyc();
        bus.WR_EN = 1'b1; bus.WR_ADDR = 5'd3; bus.WR_DATA = 8'hAA;
        cyc();
        bus.WR_EN = 1'b0;
        compared++;
        if (bus.SAMPLE !== 8'd24) begin
            mismatched++; $display("FAIL collision_old: got %0d want 24", bus.SAMPLE);
        end
        repeat (32) cyc();
        compared++;
        if (bus.SAMPLE !== 8'hAA || bus.SAMPLE !== 8'(m_sample)) begin
            mismatched++; $display("FAIL collision_new: got %0h want aa", bus.SAMPLE);
        end
        bus.Switch = 1'b0;
        wr(3, 24);
    endtask

    task automatic test_random();
        bus.Switch = 1'b1; bus.FREQ = 16'($urandom);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(31) == 0) bus.Switch = ~bus.Switch;
            if ($urandom_range(7) == 0) bus.FREQ = 16'($urandom);
            bus.WR_EN = ($urandom_range(3) == 0); bus.WR_ADDR = 5'($urandom); bus.WR_DATA = 8'($urandom);
            cyc();
            compared++;
            if ({bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit} !== {8'(m_sample), m_stb[0], m_bit[0]}) begin
                mismatched++; $display("FAIL random %0d: got s=%0d stb=%0b bit=%0b want s=%0d stb=%0d bit=%0d", k, bus.SAMPLE, bus.SAMPLE_STB, bus.AudioBit, m_sample, m_stb, m_bit);
            end
        end
        bus.WR_EN = 1'b0; bus.Switch = 1'b0; cyc();
    endtask

    task automatic test_audio(input int v);
        int ones;
        logic prev;
        fill(v);
        bus.FREQ = 16'($urandom); bus.Switch = 1'b1;
        repeat (2) cyc();
        prev = bus.AudioBit; ones = 0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            ones += int'(bus.AudioBit);
            compared++;
            if (bus.AudioBit !== m_bit[0]) begin
                mismatched++; $display("FAIL audio_%0h cyc %0d: got %0b want %0d", v, k, bus.AudioBit, m_bit);
            end
`ifdef WAVETABLE_PDM_EN
            if (v == 8'h80) begin
                compared++;
                if (bus.AudioBit !== ~prev) begin
                    mismatched++; $display("FAIL pdm_toggle cyc %0d: got %0b want %0b", k, bus.AudioBit, ~prev);
                end
            end
`endif
            prev = bus.AudioBit;
        end
        compared++;
`ifdef WAVETABLE_PDM_EN
        if (ones != v / 16) begin
            mismatched++; $display("FAIL pdm_density_%0h: got %0d ones want %0d", v, ones, v / 16);
        end
`else
        if (ones != (v >= 128 ? 16 : 0)) begin
            mismatched++; $display("FAIL msb_density_%0h: got %0d ones want %0d", v, ones, v >= 128 ? 16 : 0);
        end
`endif
        bus.Switch = 1'b0; cyc();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_half_zero();
        test_prescale();
        test_switch_reset();
        test_collision();
        test_random();
        test_audio(8'h80);
        test_audio(8'h40);
        test_audio(8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
